// File: rtl/sentinel_key_presenter_if.sv
// Signal bundle between the Sentinel key presenter (master) and the gate/fixture side (slave).
// The port named "release" in the block description is carried as hold_release because release is a SystemVerilog keyword.
interface sentinel_key_presenter_if;
    // start is a level request taken only while busy is low; done is a one-cycle
    // completion pulse, and granted/denied/fault hold until the next accepted start.
    logic       start;
    logic [7:0] key_in;
    logic       hold_release;
    logic [7:0] seg_in;
    logic [7:0] glow_in;
    logic [7:0] key_out;
    logic       busy;
    logic       done;
    logic       granted;
    logic       denied;
    logic       fault;
    logic [1:0] attempts;
    logic [2:0] dbg_state;

    modport master (
        input  start, key_in, hold_release, seg_in, glow_in,
        output key_out, busy, done, granted, denied, fault, attempts, dbg_state
    );

    modport slave (
        output start, key_in, hold_release, seg_in, glow_in,
        input  key_out, busy, done, granted, denied, fault, attempts, dbg_state
    );
endinterface

// File: rtl/sentinel_key_presenter.sv
// Presents a captured key to a Sentinel gate, classifies its seg/glow answer, retries on LOCK.
// Optional key hold after grant is enabled with the SENTINEL_HOLD_EN macro.
module sentinel_key_presenter #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_ATTEMPTS   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sentinel_key_presenter_if.master   bus
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_SAT   = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_SAT  = TW'(TIMEOUT_CYCLES);
    localparam logic [1:0]    ATT_MAX      = 2'(MAX_ATTEMPTS);

`ifdef SENTINEL_HOLD_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_RELEASE, ST_HOLD
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_RELEASE
    } state_t;
`endif

    typedef enum logic [2:0] {
        CLS_NONE, CLS_GRANT, CLS_LOCK, CLS_OFF, CLS_BAD
    } cls_t;

    state_t        state_q, state_n;
    cls_t          cls, prev_q, prev_n;
    logic [7:0]    key_q, key_n;
    logic [SW-1:0] settle_q, settle_n;
    logic [TW-1:0] timeout_q, timeout_n;
    logic          done_q, done_n;
    logic          granted_q, granted_n;
    logic          denied_q, denied_n;
    logic          fault_q, fault_n;
    logic [1:0]    attempts_q, attempts_n;
    logic          decided;

    always_comb begin
        cls = CLS_BAD;
        if (bus.seg_in == 8'hC1 && bus.glow_in == 8'hFF)      cls = CLS_GRANT;
        else if (bus.seg_in == 8'hC7 && bus.glow_in == 8'h00) cls = CLS_LOCK;
        else if (bus.seg_in == 8'hFF && bus.glow_in == 8'h00) cls = CLS_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            prev_q     <= CLS_NONE;
            key_q      <= '0;
            settle_q   <= '0;
            timeout_q  <= '0;
            done_q     <= 1'b0;
            granted_q  <= 1'b0;
            denied_q   <= 1'b0;
            fault_q    <= 1'b0;
            attempts_q <= '0;
        end else begin
            state_q    <= state_n;
            prev_q     <= prev_n;
            key_q      <= key_n;
            settle_q   <= settle_n;
            timeout_q  <= timeout_n;
            done_q     <= done_n;
            granted_q  <= granted_n;
            denied_q   <= denied_n;
            fault_q    <= fault_n;
            attempts_q <= attempts_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        prev_n     = prev_q;
        key_n      = key_q;
        settle_n   = settle_q;
        timeout_n  = timeout_q;
        done_n     = 1'b0;
        granted_n  = granted_q;
        denied_n   = denied_q;
        fault_n    = fault_q;
        attempts_n = attempts_q;
        decided    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    key_n      = bus.key_in;
                    granted_n  = 1'b0;
                    denied_n   = 1'b0;
                    fault_n    = 1'b0;
                    attempts_n = 2'd1;
                    settle_n   = '0;
                    state_n    = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                if (settle_q >= SETTLE_LAST) begin
                    timeout_n = '0;
                    prev_n    = CLS_NONE;
                    state_n   = ST_SAMPLE;
                end else if (settle_q != SETTLE_SAT) begin
                    settle_n = settle_q + 1'b1;
                end
            end

            ST_SAMPLE: begin
                prev_n = cls;
                if (timeout_q != TIMEOUT_SAT) timeout_n = timeout_q + 1'b1;
                // OFF never decides, and CLS_NONE in prev_q blocks a decision on the first sample.
                if (cls == prev_q) begin
                    case (cls)
                        CLS_GRANT: begin
                            decided   = 1'b1;
                            granted_n = 1'b1;
                            done_n    = 1'b1;
`ifdef SENTINEL_HOLD_EN
                            prev_n    = CLS_GRANT;
                            state_n   = ST_HOLD;
`else
                            state_n   = ST_IDLE;
`endif
                        end
                        CLS_LOCK: begin
                            decided = 1'b1;
                            if (attempts_q < ATT_MAX) begin
                                attempts_n = attempts_q + 2'd1;
                                settle_n   = '0;
                                state_n    = ST_RELEASE;
                            end else begin
                                denied_n = 1'b1;
                                done_n   = 1'b1;
                                state_n  = ST_IDLE;
                            end
                        end
                        CLS_BAD: begin
                            decided = 1'b1;
                            fault_n = 1'b1;
                            done_n  = 1'b1;
                            state_n = ST_IDLE;
                        end
                        default: ;
                    endcase
                end
                if (!decided && timeout_q >= TIMEOUT_LAST) begin
                    fault_n = 1'b1;
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end

            ST_RELEASE: begin
                if (settle_q >= SETTLE_LAST) begin
                    settle_n = '0;
                    state_n  = ST_DRIVE;
                end else if (settle_q != SETTLE_SAT) begin
                    settle_n = settle_q + 1'b1;
                end
            end

`ifdef SENTINEL_HOLD_EN
            ST_HOLD: begin
                // prev_q tracks whether the previous HOLD cycle already saw seg_in off 0xC1.
                prev_n = (bus.seg_in != 8'hC1) ? CLS_BAD : CLS_GRANT;
                if (bus.hold_release) begin
                    state_n = ST_IDLE;
                end else if (bus.seg_in != 8'hC1 && prev_q == CLS_BAD) begin
                    granted_n = 1'b0;
                    fault_n   = 1'b1;
                    done_n    = 1'b1;
                    state_n   = ST_IDLE;
                end
            end
`endif

            default: state_n = ST_IDLE;
        endcase
    end

`ifndef SENTINEL_HOLD_EN
    logic unused_hold_release;
    assign unused_hold_release = bus.hold_release;
`endif

    always_comb begin
        bus.key_out = 8'h00;
        case (state_q)
            ST_DRIVE, ST_SAMPLE: bus.key_out = key_q;
`ifdef SENTINEL_HOLD_EN
            ST_HOLD:             bus.key_out = key_q;
`endif
            default:             bus.key_out = 8'h00;
        endcase
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.granted   = granted_q;
    assign bus.denied    = denied_q;
    assign bus.fault     = fault_q;
    assign bus.attempts  = attempts_q;
    assign bus.dbg_state = state_q;

endmodule
